lift_ctrl_n: RTL and testbench

- Parametrised multi-floor lift controller; the next generation of the 4-floor lift FSM.
- Takes one target-floor request at a time over a valid/ready handshake from the upstream request queue. The valid/ready pair replaces the old qEmpty/done pairing.
- Drives direction per floor step with a programmable travel time, holds a door-dwell period on arrival, then pulses done.
- Sits between the request queue and the motor/door drivers.

---
 rtl/lift_ctrl_n_if.sv | 24 ++
 rtl/lift_ctrl_n.sv | 152 +++++++++++++++
 tb/tb_lift_ctrl_n.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_ctrl_n_if.sv
// Request/status bundle between the request queue (master) and the lift
// controller (slave). FLOOR_W must match the controller's FLOOR_W.
interface lift_ctrl_n_if #(
  parameter int FLOOR_W = 3
) ();
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_ready;
  logic [FLOOR_W-1:0] floor;
  logic [1:0]         dout;
  logic               door_open;
  logic               done;
  logic               err;

  modport master (
    output req_valid, req_floor,
    input  req_ready, floor, dout, door_open, done, err
  );

  modport slave (
    input  req_valid, req_floor,
    output req_ready, floor, dout, door_open, done, err
  );
endinterface

// File: rtl/lift_ctrl_n.sv
// Multi-floor lift controller: accepts one target floor per valid/ready
// handshake, steps the cabin one floor per TRAVEL_CYC cycles, holds the
// door for DWELL_CYC cycles on arrival, then pulses done for one cycle.
// Out-of-range targets are rejected with a one-cycle err pulse.
// Optional emergency stop freeze is enabled by defining LIFT_ESTOP_EN.
module lift_ctrl_n #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int DWELL_CYC  = 2,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef LIFT_ESTOP_EN
  input  logic         estop,
`endif
  lift_ctrl_n_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic [1:0] DOUT_UP   = 2'b00;
  localparam logic [1:0] DOUT_DOWN = 2'b01;
  localparam logic [1:0] DOUT_STAY = 2'b10;

  localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [CNT_W-1:0]   DWELL_LAST  = CNT_W'(DWELL_CYC - 1);
  // One extra bit so FLOORS == 2^FLOOR_W still compares correctly.
  localparam logic [FLOOR_W:0]   FLOORS_EXT  = (FLOOR_W + 1)'(FLOORS);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [FLOOR_W-1:0] floor_reg, floor_next;
  logic [FLOOR_W-1:0] target_reg, target_next;
  logic               dir_up_reg, dir_up_next;
  logic               door_open_reg, door_open_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic               freeze;
  logic               accept;
  logic               out_of_range;
  logic [FLOOR_W-1:0] floor_step;

`ifdef LIFT_ESTOP_EN
  assign freeze = estop;
`else
  assign freeze = 1'b0;
`endif

  // Handshake and motion decode depend on state/dir (and the freeze) only.
  assign bus.req_ready = (state_reg == IDLE) && !freeze;
  assign bus.dout      = (state_reg == MOVE && !freeze)
                         ? (dir_up_reg ? DOUT_UP : DOUT_DOWN)
                         : DOUT_STAY;
  assign bus.floor     = floor_reg;
  assign bus.door_open = door_open_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;

  assign accept       = bus.req_valid && bus.req_ready;
  assign out_of_range = {1'b0, bus.req_floor} >= FLOORS_EXT;
  // Target is always inside 0..FLOORS-1, so a step never wraps.
  assign floor_step   = dir_up_reg ? floor_reg + FLOOR_W'(1)
                                   : floor_reg - FLOOR_W'(1);

  // Next-state, counter, floor and registered-output computation.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    floor_next     = floor_reg;
    target_next    = target_reg;
    dir_up_next    = dir_up_reg;
    door_open_next = door_open_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;

    if (!freeze) begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (out_of_range) begin
              err_next = 1'b1;
            end else if (bus.req_floor == floor_reg) begin
              state_next = DOOR;
              cnt_next   = '0;
            end else begin
              target_next = bus.req_floor;
              dir_up_next = bus.req_floor > floor_reg;
              state_next  = MOVE;
              cnt_next    = '0;
            end
          end
        end
        MOVE: begin
          if (cnt_reg == TRAVEL_LAST) begin
            cnt_next   = '0;
            floor_next = floor_step;
            if (floor_step == target_reg) begin
              state_next = DOOR;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        DOOR: begin
          if (cnt_reg == DWELL_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
      door_open_next = (state_next == DOOR);
    end
  end

  // State and output registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      floor_reg     <= '0;
      target_reg    <= '0;
      dir_up_reg    <= 1'b0;
      door_open_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      floor_reg     <= floor_next;
      target_reg    <= target_next;
      dir_up_reg    <= dir_up_next;
      door_open_reg <= door_open_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_lift_ctrl_n.sv
// Directed testbench for lift_ctrl_n: trips up/down, same-floor request,
// out-of-range rejection, back-to-back acceptance and reset mid-move.
// With LIFT_ESTOP_EN defined, also checks the estop freeze timing.
module tb_lift_ctrl_n;
  localparam int FLOORS     = 8;
  localparam int FLOOR_W    = 4;
  localparam int TRAVEL_CYC = 4;
  localparam int DWELL_CYC  = 2;
  localparam int CNT_W      = 8;

  localparam logic [1:0] UP   = 2'b00;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic [1:0] STAY = 2'b10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef LIFT_ESTOP_EN
  logic estop = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  lift_ctrl_n_if #(.FLOOR_W(FLOOR_W)) bus ();

  lift_ctrl_n #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .TRAVEL_CYC(TRAVEL_CYC),
    .DWELL_CYC(DWELL_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef LIFT_ESTOP_EN
    .estop(estop),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Present a request for exactly one clock edge; returns on the negedge
  // after the accept edge (sample index 0 of the transaction).
  task automatic issue(input int f);
    bus.req_valid = 1'b1;
    bus.req_floor = FLOOR_W'(f);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_floor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.floor, bus.dout, bus.door_open, bus.done, bus.err} !==
        {1'b1, FLOOR_W'(0), STAY, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset ready=%b floor=%0d dout=%b door=%b done=%b err=%b expected 1 0 10 0 0 0",
               bus.req_ready, bus.floor, bus.dout, bus.door_open, bus.done, bus.err);
      // counted below
    if ({bus.req_ready, bus.floor, bus.dout, bus.door_open, bus.done, bus.err} !==
        {1'b1, FLOOR_W'(0), STAY, 1'b0, 1'b0, 1'b0}) errors++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.dout !== STAY) begin
      errors++;
      $display("FAIL reset_idle ready=%b dout=%b expected 1 10", bus.req_ready, bus.dout);
    end
    $display("reset: done");
  endtask

  // One full trip start->target, checked every cycle against the timeline:
  // d*TRAVEL_CYC cycles moving, DWELL_CYC cycles door, then one done cycle.
  task automatic test_travel(input int start, input int target, input string name);
    int d;
    bit up;
    int last;
    logic [1:0]         exp_dout;
    logic [FLOOR_W-1:0] exp_floor;
    logic               exp_door, exp_done, exp_ready;
    d    = (target > start) ? target - start : start - target;
    up   = (target > start);
    last = d * TRAVEL_CYC + DWELL_CYC + 1;
    checks++;
    if (bus.floor !== FLOOR_W'(start)) begin
      errors++;
      $display("FAIL %s_start floor=%0d expected %0d", name, bus.floor, start);
    end
    issue(target);
    for (int k = 0; k <= last; k++) begin
      if (k < d * TRAVEL_CYC) begin
        exp_dout  = up ? UP : DOWN;
        exp_floor = FLOOR_W'(up ? start + k / TRAVEL_CYC : start - k / TRAVEL_CYC);
        exp_door  = 1'b0;
        exp_done  = 1'b0;
        exp_ready = 1'b0;
      end else if (k < d * TRAVEL_CYC + DWELL_CYC) begin
        exp_dout  = STAY;
        exp_floor = FLOOR_W'(target);
        exp_door  = 1'b1;
        exp_done  = 1'b0;
        exp_ready = 1'b0;
      end else begin
        exp_dout  = STAY;
        exp_floor = FLOOR_W'(target);
        exp_door  = 1'b0;
        exp_done  = (k == d * TRAVEL_CYC + DWELL_CYC);
        exp_ready = 1'b1;
      end
      checks++;
      if ({bus.dout, bus.floor, bus.door_open, bus.done, bus.err, bus.req_ready} !==
          {exp_dout, exp_floor, exp_door, exp_done, 1'b0, exp_ready}) begin
        errors++;
        $display("FAIL %s k=%0d got dout=%b floor=%0d door=%b done=%b err=%b ready=%b expected dout=%b floor=%0d door=%b done=%b err=0 ready=%b",
                 name, k, bus.dout, bus.floor, bus.door_open, bus.done, bus.err, bus.req_ready,
                 exp_dout, exp_floor, exp_door, exp_done, exp_ready);
      end
      if (k < last) @(negedge clk);
    end
    $display("%s: trip %0d->%0d checked over %0d cycles", name, start, target, last + 1);
  endtask

  task automatic test_out_of_range();
    issue(9);
    checks++;
    if ({bus.err, bus.done, bus.req_ready, bus.floor, bus.dout, bus.door_open} !==
        {1'b1, 1'b0, 1'b1, FLOOR_W'(1), STAY, 1'b0}) begin
      errors++;
      $display("FAIL out_of_range err=%b done=%b ready=%b floor=%0d dout=%b door=%b expected 1 0 1 1 10 0",
               bus.err, bus.done, bus.req_ready, bus.floor, bus.dout, bus.door_open);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.err, bus.done, bus.req_ready, bus.floor} !== {1'b0, 1'b0, 1'b1, FLOOR_W'(1)}) begin
        errors++;
        $display("FAIL out_of_range_after k=%0d err=%b done=%b ready=%b floor=%0d expected 0 0 1 1",
                 k, bus.err, bus.done, bus.req_ready, bus.floor);
      end
    end
    $display("out_of_range: request 9 rejected");
  endtask

  task automatic test_back_to_back();
    int seen;
    issue(2);
    // Hold the next request while the first is in flight; it must be ignored.
    bus.req_valid = 1'b1;
    bus.req_floor = FLOOR_W'(5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        checks++;
        if (bus.req_ready !== 1'b0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_busy k=%0d ready=%b done=%b expected 0 0", k, bus.req_ready, bus.done);
        end
      end
    end
    checks++;
    if ({bus.done, bus.req_ready, bus.floor} !== {1'b1, 1'b1, FLOOR_W'(2)}) begin
      errors++;
      $display("FAIL b2b_done done=%b ready=%b floor=%0d expected 1 1 2",
               bus.done, bus.req_ready, bus.floor);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.dout, bus.req_ready, bus.done, bus.floor} !== {UP, 1'b0, 1'b0, FLOOR_W'(2)}) begin
      errors++;
      $display("FAIL b2b_accept dout=%b ready=%b done=%b floor=%0d expected 00 0 0 2",
               bus.dout, bus.req_ready, bus.done, bus.floor);
    end
    seen = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = j;
        break;
      end
    end
    checks++;
    if (seen != 14 || bus.floor !== FLOOR_W'(5)) begin
      errors++;
      $display("FAIL b2b_second done_at=%0d floor=%0d expected 14 5", seen, bus.floor);
    end
    $display("back_to_back: 1->2 then 2->5, second done at cycle %0d", seen);
  endtask

  task automatic test_reset_mid_move();
    int bad;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    checks++;
    if (bus.floor !== FLOOR_W'(1) || bus.dout !== UP) begin
      errors++;
      $display("FAIL rst_mid_pre floor=%0d dout=%b expected 1 00", bus.floor, bus.dout);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.floor, bus.req_ready, bus.dout, bus.done, bus.door_open} !==
        {FLOOR_W'(0), 1'b1, STAY, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid floor=%0d ready=%b dout=%b done=%b door=%b expected 0 1 10 0 0",
               bus.floor, bus.req_ready, bus.dout, bus.done, bus.door_open);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.dout !== STAY || bus.floor !== FLOOR_W'(0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet bad_cycles=%0d expected 0", bad);
    end
    $display("reset_mid_move: request aborted");
  endtask

`ifdef LIFT_ESTOP_EN
  task automatic test_estop();
    int seen;
    int bad;
    issue(3);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    estop = 1'b1;
    bad = 0;
    for (int k = 6; k <= 10; k++) begin
      @(negedge clk);
      if (bus.dout !== STAY || bus.req_ready !== 1'b0 || bus.floor !== FLOOR_W'(1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL estop_freeze bad_cycles=%0d expected 0", bad);
    end
    estop = 1'b0;
    seen = -1;
    for (int k = 11; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = k;
        break;
      end
    end
    checks++;
    if (seen != 19 || bus.floor !== FLOOR_W'(3)) begin
      errors++;
      $display("FAIL estop_resume done_at=%0d floor=%0d expected 19 3", seen, bus.floor);
    end
    $display("estop: 5-cycle freeze, done at cycle %0d", seen);
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_floor = '0;
    @(negedge clk);
    test_reset();
`ifdef LIFT_ESTOP_EN
    test_estop();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    test_travel(0, 3, "up_0_to_3");
    test_travel(3, 1, "down_3_to_1");
    test_travel(1, 1, "same_floor_1");
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_move();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
